// File: rtl/alu_decode_stage.sv
// LA32R decode/operand-select stage: decodes one instruction per cycle into a one-hot
// ALU control word plus both operands, held in a single-entry valid/ready register.
module alu_decode_stage #(
  parameter int OP_W   = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [31:0]       in_inst,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_illegal,
  output logic [DATA_W-1:0] out_pc
);
  localparam int B_ADD = 0, B_IMM = 1, B_OR = 2, B_SUB = 3, B_XOR = 4, B_SRA = 5,
                 B_AND = 6, B_SLL = 7, B_SRL = 8, B_SLTU = 9, B_NOR = 10, B_SLT = 11;

  logic [OP_W-1:0]   d_op;
  logic [DATA_W-1:0] d_src1, d_src2, rj_val, rk_val, si12, zi12, ui20, ui5;
  logic              d_legal;

  assign rf_raddr1 = in_inst[9:5];
  assign rf_raddr2 = in_inst[14:10];
  assign in_ready  = !out_valid || out_ready;

  // r0 reads as zero no matter what the register file returns
  assign rj_val = (rf_raddr1 == 5'd0) ? '0 : rf_rdata1;
  assign rk_val = (rf_raddr2 == 5'd0) ? '0 : rf_rdata2;
  assign si12   = {{20{in_inst[21]}}, in_inst[21:10]};
  assign zi12   = {20'd0, in_inst[21:10]};
  assign ui20   = {in_inst[24:5], 12'd0};
  assign ui5    = {27'd0, in_inst[14:10]};

  always_comb begin
    d_op    = '0;
    d_src1  = '0;
    d_src2  = '0;
    d_legal = 1'b1;
    case (in_inst[31:15])
      17'h20:  begin d_op[B_ADD]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h22:  begin d_op[B_SUB]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h24:  begin d_op[B_SLT]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h25:  begin d_op[B_SLTU] = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h28:  begin d_op[B_NOR]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h29:  begin d_op[B_AND]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h2a:  begin d_op[B_OR]   = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h2b:  begin d_op[B_XOR]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h2e:  begin d_op[B_SLL]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h2f:  begin d_op[B_SRL]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h30:  begin d_op[B_SRA]  = 1'b1; d_src1 = rj_val; d_src2 = rk_val; end
      17'h81:  begin d_op[B_SLL]  = 1'b1; d_src1 = rj_val; d_src2 = ui5; end
      17'h89:  begin d_op[B_SRL]  = 1'b1; d_src1 = rj_val; d_src2 = ui5; end
      17'h91:  begin d_op[B_SRA]  = 1'b1; d_src1 = rj_val; d_src2 = ui5; end
      default: begin
        case (in_inst[31:22])
          10'h00a: begin d_op[B_ADD]  = 1'b1; d_src1 = rj_val; d_src2 = si12; end
          10'h008: begin d_op[B_SLT]  = 1'b1; d_src1 = rj_val; d_src2 = si12; end
          10'h009: begin d_op[B_SLTU] = 1'b1; d_src1 = rj_val; d_src2 = si12; end
          10'h00d: begin d_op[B_AND]  = 1'b1; d_src1 = rj_val; d_src2 = zi12; end
          10'h00e: begin d_op[B_OR]   = 1'b1; d_src1 = rj_val; d_src2 = zi12; end
          10'h00f: begin d_op[B_XOR]  = 1'b1; d_src1 = rj_val; d_src2 = zi12; end
          default: begin
            case (in_inst[31:25])
              7'h0a:   begin d_op[B_IMM] = 1'b1; d_src1 = ui20; end
              7'h0e:   begin d_op[B_ADD] = 1'b1; d_src1 = in_pc; d_src2 = ui20; end
              default: d_legal = 1'b0;
            endcase
          end
        endcase
      end
    endcase
  end

  // flush beats an incoming transfer; the data registers only move on an accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_op      <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      out_rd      <= '0;
      out_wen     <= 1'b0;
      out_illegal <= 1'b0;
      out_pc      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      alu_op      <= d_op;
      alu_src1    <= d_src1;
      alu_src2    <= d_src2;
      out_rd      <= in_inst[4:0];
      out_wen     <= d_legal && (in_inst[4:0] != 5'd0);
      out_illegal <= !d_legal;
      out_pc      <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: vector table for decode, hand sequences for
// backpressure, flush and asynchronous reset.
module tb_alu_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_ready = 1'b1;
  logic [31:0] in_pc = '0, in_inst = '0, rf_rdata1 = '0, rf_rdata2 = '0;
  logic [4:0]  rf_raddr1, rf_raddr2, out_rd;
  logic        out_valid, out_wen, out_illegal;
  logic [13:0] alu_op;
  logic [31:0] alu_src1, alu_src2, out_pc;

  int total = 0, bad = 0;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst, pc, rd1, rd2;
    logic [13:0] op;
    logic [31:0] s1, s2;
    logic [4:0]  rd;
    logic        wen, ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] e3r(logic [16:0] op, logic [4:0] rk, logic [4:0] rj, logic [4:0] rd);
    return {op, rk, rj, rd};
  endfunction

  function automatic logic [31:0] e2ri(logic [9:0] op, logic [11:0] imm, logic [4:0] rj, logic [4:0] rd);
    return {op, imm, rj, rd};
  endfunction

  task automatic add(string n, logic [31:0] inst, logic [31:0] pc, logic [31:0] rd1, logic [31:0] rd2,
                     logic [13:0] op, logic [31:0] s1, logic [31:0] s2, logic [4:0] rd, logic wen, logic ill);
    vec_t v;
    v.name = n; v.inst = inst; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2;
    v.op = op; v.s1 = s1; v.s2 = s2; v.rd = rd; v.wen = wen; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(string n);
    chk({n, " valid"}, {31'd0, out_valid}, 32'd0);
    chk({n, " op"}, {18'd0, alu_op}, 32'd0);
    chk({n, " src1"}, alu_src1, 32'd0);
    chk({n, " src2"}, alu_src2, 32'd0);
    chk({n, " rd"}, {27'd0, out_rd}, 32'd0);
    chk({n, " wen"}, {31'd0, out_wen}, 32'd0);
    chk({n, " ill"}, {31'd0, out_illegal}, 32'd0);
    chk({n, " pc"}, out_pc, 32'd0);
  endtask

  initial begin
    add("add.w", 32'h00100823, 32'h100, 5, 7, 14'h0001, 5, 7, 3, 1, 0);
    add("sub.w", e3r(17'h22, 2, 1, 6), 32'h104, 10, 3, 14'h0008, 10, 3, 6, 1, 0);
    add("slt", e3r(17'h24, 9, 8, 7), 32'h108, 32'h80000000, 1, 14'h0800, 32'h80000000, 1, 7, 1, 0);
    add("sltu", e3r(17'h25, 9, 8, 7), 32'h10c, 3, 4, 14'h0200, 3, 4, 7, 1, 0);
    add("nor", e3r(17'h28, 2, 1, 5), 32'h110, 32'hf0, 32'h0f, 14'h0400, 32'hf0, 32'h0f, 5, 1, 0);
    add("and", e3r(17'h29, 2, 1, 5), 32'h114, 6, 3, 14'h0040, 6, 3, 5, 1, 0);
    add("or", e3r(17'h2a, 2, 1, 5), 32'h118, 6, 3, 14'h0004, 6, 3, 5, 1, 0);
    add("xor", e3r(17'h2b, 2, 1, 5), 32'h11c, 6, 3, 14'h0010, 6, 3, 5, 1, 0);
    add("sll.w", e3r(17'h2e, 2, 1, 5), 32'h120, 1, 4, 14'h0080, 1, 4, 5, 1, 0);
    add("srl.w", e3r(17'h2f, 2, 1, 5), 32'h124, 16, 2, 14'h0100, 16, 2, 5, 1, 0);
    add("sra.w", e3r(17'h30, 2, 1, 5), 32'h128, 32'h80000000, 3, 14'h0020, 32'h80000000, 3, 5, 1, 0);
    add("slli.w", e3r(17'h81, 31, 2, 1), 32'h12c, 9, 32'h77, 14'h0080, 9, 31, 1, 1, 0);
    add("srli.w", e3r(17'h89, 5, 2, 1), 32'h130, 9, 32'h77, 14'h0100, 9, 5, 1, 1, 0);
    add("srai.w", e3r(17'h91, 1, 2, 1), 32'h134, 9, 32'h77, 14'h0020, 9, 1, 1, 1, 0);
    add("addi r0", 32'h02bffc04, 32'h138, 32'hdeadbeef, 0, 14'h0001, 0, 32'hffffffff, 4, 1, 0);
    add("slti", e2ri(10'h008, 12'h800, 1, 3), 32'h13c, 8, 0, 14'h0800, 8, 32'hfffff800, 3, 1, 0);
    add("sltui", e2ri(10'h009, 12'h7ff, 1, 3), 32'h140, 8, 0, 14'h0200, 8, 32'h000007ff, 3, 1, 0);
    add("andi", e2ri(10'h00d, 12'hfff, 1, 3), 32'h144, 8, 0, 14'h0040, 8, 32'h00000fff, 3, 1, 0);
    add("ori", e2ri(10'h00e, 12'h800, 1, 3), 32'h148, 8, 0, 14'h0004, 8, 32'h00000800, 3, 1, 0);
    add("xori", e2ri(10'h00f, 12'h123, 1, 3), 32'h14c, 8, 0, 14'h0010, 8, 32'h00000123, 3, 1, 0);
    add("lu12i.w", 32'h142468a5, 32'h150, 32'h99, 32'h98, 14'h0002, 32'h12345000, 0, 5, 1, 0);
    add("pcaddu12i", 32'h1c2468a5, 32'h1c000000, 32'h99, 32'h98, 14'h0001, 32'h1c000000, 32'h12345000, 5, 1, 0);
    add("illegal ff", 32'hffffffff, 32'h154, 1, 2, 14'h0000, 0, 0, 31, 0, 1);
    add("illegal 3r", e3r(17'h21, 2, 1, 3), 32'h158, 1, 2, 14'h0000, 0, 0, 3, 0, 1);
    add("add rd0", e3r(17'h20, 2, 1, 0), 32'h15c, 1, 2, 14'h0001, 1, 2, 0, 0, 0);
    add("add rk0", e3r(17'h20, 0, 1, 3), 32'h160, 4, 32'h55, 14'h0001, 4, 0, 3, 1, 0);

    // reset state, while rst is still asserted
    #2;
    chk_reset_vals("reset");
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;

    // combinational read addresses
    in_inst = 32'h00100823;
    #1;
    chk("raddr1", {27'd0, rf_raddr1}, 32'd1);
    chk("raddr2", {27'd0, rf_raddr2}, 32'd2);

    // decode table, back-to-back with out_ready high
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
      rf_rdata1 = vecs[i].rd1; rf_rdata2 = vecs[i].rd2;
      step();
      chk({vecs[i].name, " valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, " op"}, {18'd0, alu_op}, {18'd0, vecs[i].op});
      chk({vecs[i].name, " src1"}, alu_src1, vecs[i].s1);
      chk({vecs[i].name, " src2"}, alu_src2, vecs[i].s2);
      chk({vecs[i].name, " rd"}, {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk({vecs[i].name, " wen"}, {31'd0, out_wen}, {31'd0, vecs[i].wen});
      chk({vecs[i].name, " ill"}, {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      chk({vecs[i].name, " pc"}, out_pc, vecs[i].pc);
    end
    in_valid = 1'b0;
    step();
    chk("drain valid", {31'd0, out_valid}, 32'd0);
    chk("drain hold src1", alu_src1, 32'd4);

    // backpressure: A accepted, B held on input for 3 stalled cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100823; in_pc = 32'h200; rf_rdata1 = 5; rf_rdata2 = 7;
    step();
    in_inst = e3r(17'h22, 2, 1, 6); in_pc = 32'h204; rf_rdata1 = 10; rf_rdata2 = 3;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("stall valid", {31'd0, out_valid}, 32'd1);
      chk("stall src1", alu_src1, 32'd5);
      chk("stall op", {18'd0, alu_op}, 32'h0001);
      chk("stall pc", out_pc, 32'h200);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("B valid", {31'd0, out_valid}, 32'd1);
    chk("B op", {18'd0, alu_op}, 32'h0008);
    chk("B src1", alu_src1, 32'd10);
    chk("B pc", out_pc, 32'h204);
    step();
    chk("B drained", {31'd0, out_valid}, 32'd0);

    // flush coincident with an input: input dropped, still consumed
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h142468a5; in_pc = 32'h300;
    #1;
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    chk("flush dropped pc", out_pc, 32'h204);

    // flush of a held packet during a stall
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre-flush valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush held valid", {31'd0, out_valid}, 32'd0);

    // reset pulsed mid-stall clears everything without a clock edge
    in_valid = 1'b1; in_inst = 32'h142468a5; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    chk("pre-rst valid", {31'd0, out_valid}, 32'd1);
    chk("pre-rst src1", alu_src1, 32'h12345000);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("async rst");
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post-rst valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode/operand-select stage that produces the 14-bit ALU control word and both 32-bit ALU operands for the execute-stage ALU.
- Accepts one fetched LA32R instruction per cycle with its PC, reads two register-file ports combinationally, and launches one decoded ALU packet downstream over a valid/ready handshake.
- Sits between fetch/issue and the execute-stage ALU, which consumes alu_op, alu_src1 and alu_src2.

Parameters:
- OP_W, 14, width of alu_op.
- DATA_W, 32, operand and PC width. Fixed at 32 for LA32R.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard the held packet and any input this cycle.
- in_valid  input  1  upstream packet valid.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  32  PC of the instruction.
- in_inst  input  32  instruction word.
- rf_raddr1  output  5  combinational, equals in_inst[9:5] (rj).
- rf_raddr2  output  5  combinational, equals in_inst[14:10] (rk).
- rf_rdata1  input  32  same-cycle read data for rf_raddr1.
- rf_rdata2  input  32  same-cycle read data for rf_raddr2.
- out_valid  output  1  decoded packet valid.
- out_ready  input  1  downstream accepts.
- alu_op  output  14  one-hot control word.
- alu_src1  output  32  ALU operand 1.
- alu_src2  output  32  ALU operand 2.
- out_rd  output  5  destination register.
- out_wen  output  1  register write enable.
- out_illegal  output  1  instruction not recognised.
- out_pc  output  32  PC carried through.

Behaviour:
- alu_op bit map (exactly one bit set for legal instructions): 0 add, 1 imm (pass src1), 2 or, 3 sub, 4 xor, 5 sra, 6 and, 7 sll, 8 srl, 9 sltu, 10 nor, 11 slt. Bits 12-13 are always 0. nor sets only bit 10; slt/sltu never set bit 3.
- 3R forms, matched on in_inst[31:15]: 0x20 add.w, 0x22 sub.w, 0x24 slt, 0x25 sltu, 0x28 nor, 0x29 and, 0x2a or, 0x2b xor, 0x2e sll.w, 0x2f srl.w, 0x30 sra.w. src1 = rj value, src2 = rk value.
- Shift-immediate forms, matched on in_inst[31:15]: 0x81 slli.w, 0x89 srli.w, 0x91 srai.w. src1 = rj value, src2 = zext(inst[14:10]).
- 2RI12 forms, matched on in_inst[31:22]:
  - 0x00a addi.w, 0x008 slti, 0x009 sltui: src2 = sext(inst[21:10]).
  - 0x00d andi, 0x00e ori, 0x00f xori: src2 = zext(inst[21:10]).
  - src1 = rj value for all six.
- 1RI20 forms, matched on in_inst[31:25]:
  - 0x0a lu12i.w: op imm, src1 = {inst[24:5], 12'h0}, src2 = 0.
  - 0x0e pcaddu12i: op add, src1 = in_pc, src2 = {inst[24:5], 12'h0}.
- r0 handling: a read index of 0 forces the operand to 0 regardless of rf_rdata. out_rd = inst[4:0]. out_wen = legal && rd != 0.
- Illegal instruction: alu_op = 0, src1 = src2 = 0, out_wen = 0, out_illegal = 1. The packet still flows through the handshake.
- Pipeline register, single entry, latency 1 cycle:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in occurs when in_valid && in_ready. All outputs register at that edge and out_valid is set to 1.
  - On out_ready with no incoming transfer, out_valid clears to 0 and the data outputs hold their values.
  - Full throughput: back-to-back accept while out_ready = 1.
- Stall: while out_valid && !out_ready, every output is held stable and in_ready = 0.
- Flush: at the next edge out_valid = 0 and any coincident input is dropped. in_ready is still asserted the same cycle, so upstream counts the input as consumed.
- Reset, asynchronous and immediate: out_valid = 0, alu_op = 0, alu_src1 = alu_src2 = 0, out_rd = 0, out_wen = 0, out_illegal = 0, out_pc = 0. Reset asserted mid-stall discards the packet.

Test Plan:
- add.w r3,r1,r2: in_inst = 0x00100823, rdata1 = 5, rdata2 = 7 -> next cycle out_valid = 1, alu_op = 0x0001, src1 = 5, src2 = 7, rd = 3, wen = 1.
- addi.w r4,r0,-1: in_inst = 0x02bffc04, rdata1 = 0xdeadbeef -> src1 = 0 (r0 forced), src2 = 0xffffffff, alu_op = 0x0001.
- lu12i.w r5,0x12345: in_inst = 0x142468a5 -> alu_op = 0x0002, src1 = 0x12345000, src2 = 0. pcaddu12i at pc 0x1c000000 with the same immediate -> alu_op = 0x0001, src1 = 0x1c000000.
- Backpressure: out_ready = 0 for 3 cycles after one accept -> in_ready = 0 and outputs frozen. A second instruction held on in_valid is accepted on the cycle out_ready returns to 1, then appears 1 cycle later.
- in_inst = 0xffffffff -> out_illegal = 1, alu_op = 0, wen = 0. Any rd = 0 legal op -> wen = 0.
- flush coincident with in_valid, and rst pulsed while stalled -> out_valid = 0 on the next edge (flush) or immediately (rst). Every output equals its reset value after rst.
